// File: rtl/spi_ram_ctrl.sv
// Byte-wide SPI serial RAM master: one load/store per valid/ready handshake,
// framed as cs low, {cmd, addr, data} MSB-first, one bit per clk.
module spi_ram_ctrl #(
  parameter int          ADDR_W    = 24,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              cs_ram_n,
  output logic              mosi_ram,
  input  logic              miso_ram
);

  localparam int FRAME_W = 16 + ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_t;

  state_t               r_state, w_state_next;
  logic [5:0]           r_cnt, w_cnt_next;
  logic [FRAME_W-1:0]   r_shift, w_shift_next;
  logic                 r_we, w_we_next;
  logic [7:0]           r_rx, w_rx_next;
  logic                 r_cs_n, w_cs_n_next;
  logic                 r_mosi, w_mosi_next;
  logic                 r_done, w_done_next;
  logic [7:0]           r_rdata, w_rdata_next;

  logic [FRAME_W-1:0]   w_frame;
  logic                 w_accept;

  // Loads send a zero data byte so mosi stays low while the RAM drives miso.
  assign w_frame  = {(req_we ? CMD_WRITE : CMD_READ), req_addr, (req_we ? req_wdata : 8'h00)};
  assign w_accept = req_valid && (r_state == S_IDLE);

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign cs_ram_n  = r_cs_n;
  assign mosi_ram  = r_mosi;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_we_next    = r_we;
    w_rx_next    = r_rx;
    w_cs_n_next  = r_cs_n;
    w_mosi_next  = r_mosi;
    w_done_next  = 1'b0;
    w_rdata_next = r_rdata;

    if (r_state == S_IDLE) begin
      w_cs_n_next = 1'b1;
      w_mosi_next = 1'b0;
      if (w_accept) begin
        w_state_next = S_CMD;
        w_cnt_next   = 6'd7;
        w_we_next    = req_we;
        w_cs_n_next  = 1'b0;
        w_mosi_next  = w_frame[FRAME_W-1];
        w_shift_next = {w_frame[FRAME_W-2:0], 1'b0};
      end
    end else begin
      // The frame bit for the next cycle always sits at the shifter MSB.
      w_mosi_next  = r_shift[FRAME_W-1];
      w_shift_next = {r_shift[FRAME_W-2:0], 1'b0};
      w_cnt_next   = r_cnt - 6'd1;
      case (r_state)
        S_CMD: begin
          if (r_cnt == 6'd0) begin
            w_state_next = S_ADDR;
            w_cnt_next   = 6'(ADDR_W - 1);
          end
        end
        S_ADDR: begin
          if (r_cnt == 6'd0) begin
            w_state_next = S_DATA;
            w_cnt_next   = 6'd7;
          end
        end
        S_DATA: begin
          w_rx_next = {r_rx[6:0], miso_ram};
          if (r_cnt == 6'd0) begin
            w_state_next = S_IDLE;
            w_cs_n_next  = 1'b1;
            w_mosi_next  = 1'b0;
            w_done_next  = 1'b1;
            if (!r_we) begin
              w_rdata_next = {r_rx[6:0], miso_ram};
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cs_n_next  = 1'b1;
          w_mosi_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_shift <= '0;
      r_we    <= 1'b0;
      r_rx    <= 8'h00;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
      r_we    <= w_we_next;
      r_rx    <= w_rx_next;
      r_cs_n  <= w_cs_n_next;
      r_mosi  <= w_mosi_next;
      r_done  <= w_done_next;
      r_rdata <= w_rdata_next;
    end
  end

endmodule
